// File: rtl/topk_emitter.sv
// topk_emitter: snapshots the top-K slot arrays on frame_done and replays them as an AXI4-Stream, smallest first.
// Latency: first beat is registered one cycle after frame_done is accepted; one beat per cycle after that.
// Backpressure: the beat holds while tready is low; frame_done while busy is dropped and counted in overrun_count.
// Option: define TOPK_EMITTER_SKIP_INVALID_EN to list only occupied slots (otherwise every slot, tuser = occupancy).
module topk_emitter #(
  parameter int QUEUE_SIZE  = 8,
  parameter int TDATA_WIDTH = 8,
  parameter int ID_WIDTH    = 32
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              frame_done,
  input  logic [ID_WIDTH*QUEUE_SIZE-1:0]    s_ids,
  input  logic [TDATA_WIDTH*QUEUE_SIZE-1:0] s_values,
  input  logic [QUEUE_SIZE-1:0]             s_valid,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [TDATA_WIDTH+ID_WIDTH-1:0]   m_axis_tdata,
  output logic                              m_axis_tuser,
  output logic                              m_axis_tlast,
  output logic                              busy,
  output logic                              empty_frame,
  output logic [7:0]                        overrun_count
);

  localparam int IDX_W = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;
  localparam logic [QUEUE_SIZE-1:0] SLOT_ONE = QUEUE_SIZE'(1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t state, state_nxt;

  logic [ID_WIDTH-1:0]    in_ids      [QUEUE_SIZE];
  logic [TDATA_WIDTH-1:0] in_values   [QUEUE_SIZE];
  logic [ID_WIDTH-1:0]    snap_ids    [QUEUE_SIZE];
  logic [TDATA_WIDTH-1:0] snap_values [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0]  snap_valid;

  // Listed slots that still have to be sent after the beat currently on the bus.
  logic [QUEUE_SIZE-1:0]  pending;
  logic [QUEUE_SIZE-1:0]  pending_nxt;
  logic [QUEUE_SIZE-1:0]  list_in;
  logic                   list_any;
  logic                   accept;
  logic                   beat_hs;
  logic                   load_beat;
  logic [IDX_W-1:0]       sel_idx;
  logic [ID_WIDTH-1:0]    beat_id;
  logic [TDATA_WIDTH-1:0] beat_value;
  logic                   beat_user;

  // Priority search: index of the lowest set bit (0 when none is set).
  function automatic logic [IDX_W-1:0] lowest_set(input logic [QUEUE_SIZE-1:0] m);
    lowest_set = '0;
    for (int i = QUEUE_SIZE - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  for (genvar g = 0; g < QUEUE_SIZE; g++) begin : g_unpack
    assign in_ids[g]    = s_ids[g*ID_WIDTH +: ID_WIDTH];
    assign in_values[g] = s_values[g*TDATA_WIDTH +: TDATA_WIDTH];
  end

`ifdef TOPK_EMITTER_SKIP_INVALID_EN
  assign list_in = s_valid;
`else
  assign list_in = '1;
`endif

  assign list_any      = |list_in;
  assign accept        = (state == IDLE) && frame_done;
  assign beat_hs       = (state == SEND) && m_axis_tready;
  assign m_axis_tvalid = (state == SEND);
  assign busy          = (state == SEND);

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: leave IDLE on a frame with beats, return after the tlast handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_done && list_any) state_nxt = SEND;
      SEND:    if (m_axis_tready && m_axis_tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next beat: first listed slot from the live inputs on accept, else next pending slot from the snapshot.
  always_comb begin
    sel_idx     = '0;
    pending_nxt = pending;
    load_beat   = 1'b0;
    beat_id     = '0;
    beat_value  = '0;
    beat_user   = 1'b0;
    if (accept) begin
      sel_idx     = lowest_set(list_in);
      pending_nxt = list_in & ~(SLOT_ONE << sel_idx);
      load_beat   = list_any;
      beat_id     = in_ids[sel_idx];
      beat_value  = in_values[sel_idx];
      beat_user   = s_valid[sel_idx];
    end else if (beat_hs && !m_axis_tlast) begin
      sel_idx     = lowest_set(pending);
      pending_nxt = pending & ~(SLOT_ONE << sel_idx);
      load_beat   = 1'b1;
      beat_id     = snap_ids[sel_idx];
      beat_value  = snap_values[sel_idx];
      beat_user   = snap_valid[sel_idx];
    end
  end

  // Beat output registers; only change when a new beat is loaded so they hold under backpressure.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tdata <= '0;
      m_axis_tuser <= 1'b0;
      m_axis_tlast <= 1'b0;
      pending      <= '0;
    end else if (load_beat) begin
      m_axis_tdata <= {beat_value, beat_id};
      m_axis_tuser <= beat_user;
      m_axis_tlast <= (pending_nxt == '0);
      pending      <= pending_nxt;
    end
  end

  // Snapshot of the slot arrays, captured only when a frame is accepted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        snap_ids[i]    <= '0;
        snap_values[i] <= '0;
      end
      snap_valid <= '0;
    end else if (accept) begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        snap_ids[i]    <= in_ids[i];
        snap_values[i] <= in_values[i];
      end
      snap_valid <= s_valid;
    end
  end

  // Status: empty-frame pulse and saturating count of frames dropped while busy.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      empty_frame   <= 1'b0;
      overrun_count <= '0;
    end else begin
      empty_frame <= accept && !list_any;
      if (busy && frame_done && (overrun_count != 8'hFF)) begin
        overrun_count <= overrun_count + 8'd1;
      end
    end
  end

endmodule
